// File: rtl/vp_pair_packer_if.sv
// rtl/vp_pair_packer_if.sv - job, element stream and dual output bank signals of vp_pair_packer
interface vp_pair_packer_if #(
    parameter int LANES  = 3,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 21,
    parameter int POS_W  = 9,
    parameter int W_LEN  = 6
);
    localparam int WL_W  = $clog2(W_LEN + 1);
    localparam int CNT_W = $clog2(LANES + 1);

    logic                      i_start;
    logic [WL_W-1:0]           i_w_len;
    logic [W_LEN*DATA_W-1:0]   i_w_data;
    logic                      i_in_valid;
    logic                      o_in_ready;
    logic [ADDR_W-1:0]         i_in_addr;
    logic [POS_W-1:0]          i_in_pos;
    logic [DATA_W-1:0]         i_in_ia;
    logic                      i_in_last;
    logic                      o_left_ready;
    logic                      i_left_ack;
    logic [CNT_W-1:0]          o_left_cnt;
    logic [LANES*ADDR_W-1:0]   o_left_addr;
    logic [LANES*DATA_W-1:0]   o_left_ia;
    logic [LANES*DATA_W-1:0]   o_left_w;
    logic                      o_right_ready;
    logic                      i_right_ack;
    logic [CNT_W-1:0]          o_right_cnt;
    logic [LANES*ADDR_W-1:0]   o_right_addr;
    logic [LANES*DATA_W-1:0]   o_right_ia;
    logic [LANES*DATA_W-1:0]   o_right_w;
    logic [15:0]               o_drop_cnt;
    logic                      o_done;

    modport master (
        output i_start, i_w_len, i_w_data,
        output i_in_valid, i_in_addr, i_in_pos, i_in_ia, i_in_last,
        output i_left_ack, i_right_ack,
        input  o_in_ready,
        input  o_left_ready, o_left_cnt, o_left_addr, o_left_ia, o_left_w,
        input  o_right_ready, o_right_cnt, o_right_addr, o_right_ia, o_right_w,
        input  o_drop_cnt, o_done
    );

    modport slave (
        input  i_start, i_w_len, i_w_data,
        input  i_in_valid, i_in_addr, i_in_pos, i_in_ia, i_in_last,
        input  i_left_ack, i_right_ack,
        output o_in_ready,
        output o_left_ready, o_left_cnt, o_left_addr, o_left_ia, o_left_w,
        output o_right_ready, o_right_cnt, o_right_addr, o_right_ia, o_right_w,
        output o_drop_cnt, o_done
    );
endinterface

// File: rtl/vp_pair_packer.sv
// rtl/vp_pair_packer.sv - pairs sparse activations with weights, ping-pongs LANES-wide groups
// Optional feature macro: VPENC_ZERO_SKIP_EN drops pairs whose activation or weight is zero.
module vp_pair_packer #(
    parameter int LANES  = 3,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 21,
    parameter int POS_W  = 9,
    parameter int W_LEN  = 6
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    vp_pair_packer_if.slave bus
);
    localparam int WL_W  = $clog2(W_LEN + 1);
    localparam int CNT_W = $clog2(LANES + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_FILL  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]              state_q, state_d;
    logic                    fill_bank_q, fill_bank_d;
    logic [CNT_W-1:0]        lane_cnt_q, lane_cnt_d;
    logic [WL_W-1:0]         w_len_q, w_len_d;
    logic [DATA_W-1:0]       w_tab_q [W_LEN];
    logic [DATA_W-1:0]       w_tab_d [W_LEN];
    logic [15:0]             drop_cnt_q, drop_cnt_d;
    logic                    done_q, done_d;
    // Bank 0 is the left bank, bank 1 the right bank.
    logic [1:0]              bank_ready_q, bank_ready_d;
    logic [CNT_W-1:0]        bank_cnt_q  [2];
    logic [CNT_W-1:0]        bank_cnt_d  [2];
    logic [LANES*ADDR_W-1:0] bank_addr_q [2];
    logic [LANES*ADDR_W-1:0] bank_addr_d [2];
    logic [LANES*DATA_W-1:0] bank_ia_q   [2];
    logic [LANES*DATA_W-1:0] bank_ia_d   [2];
    logic [LANES*DATA_W-1:0] bank_w_q    [2];
    logic [LANES*DATA_W-1:0] bank_w_d    [2];

    logic              in_ready;
    logic              accept;
    logic              drop;
    logic [1:0]        ack;
    logic [DATA_W-1:0] w_sel;
    logic [CNT_W-1:0]  filled;

    assign in_ready = (state_q == S_FILL) && !bank_ready_q[fill_bank_q];
    assign accept   = bus.i_in_valid && in_ready;
    assign ack      = {bus.i_right_ack, bus.i_left_ack} & bank_ready_q;

    always_comb begin
        w_sel = '0;
        for (int k = 0; k < W_LEN; k++) begin
            if (bus.i_in_pos == POS_W'(k)) w_sel = w_tab_q[k];
        end
    end

`ifdef VPENC_ZERO_SKIP_EN
    assign drop = (32'(bus.i_in_pos) >= 32'(w_len_q)) || (bus.i_in_ia == '0) || (w_sel == '0);
`else
    assign drop = (32'(bus.i_in_pos) >= 32'(w_len_q));
`endif

    always_comb begin
        state_d      = state_q;
        fill_bank_d  = fill_bank_q;
        lane_cnt_d   = lane_cnt_q;
        w_len_d      = w_len_q;
        w_tab_d      = w_tab_q;
        drop_cnt_d   = drop_cnt_q;
        done_d       = 1'b0;
        bank_ready_d = bank_ready_q;
        bank_cnt_d   = bank_cnt_q;
        bank_addr_d  = bank_addr_q;
        bank_ia_d    = bank_ia_q;
        bank_w_d     = bank_w_q;
        filled       = lane_cnt_q;

        // A released bank is zeroed so a later partial group reads 0 in unfilled lanes.
        for (int b = 0; b < 2; b++) begin
            if (ack[b]) begin
                bank_ready_d[b] = 1'b0;
                bank_cnt_d[b]   = '0;
                bank_addr_d[b]  = '0;
                bank_ia_d[b]    = '0;
                bank_w_d[b]     = '0;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    state_d = S_LOAD;
                    w_len_d = bus.i_w_len;
                    for (int k = 0; k < W_LEN; k++) w_tab_d[k] = bus.i_w_data[k*DATA_W +: DATA_W];
                end
            end
            S_LOAD: begin
                drop_cnt_d = '0;
                state_d    = S_FILL;
            end
            S_FILL: begin
                if (accept) begin
                    if (drop) begin
                        if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
                    end else begin
                        for (int l = 0; l < LANES; l++) begin
                            if (lane_cnt_q == CNT_W'(l)) begin
                                bank_addr_d[fill_bank_q][l*ADDR_W +: ADDR_W] = bus.i_in_addr;
                                bank_ia_d[fill_bank_q][l*DATA_W +: DATA_W]   = bus.i_in_ia;
                                bank_w_d[fill_bank_q][l*DATA_W +: DATA_W]    = w_sel;
                            end
                        end
                        filled = lane_cnt_q + CNT_W'(1);
                    end
                    if ((filled == CNT_W'(LANES)) || (bus.i_in_last && (filled != '0))) begin
                        bank_ready_d[fill_bank_q] = 1'b1;
                        bank_cnt_d[fill_bank_q]   = filled;
                        lane_cnt_d                = '0;
                        fill_bank_d               = ~fill_bank_q;
                    end else begin
                        lane_cnt_d = filled;
                    end
                    if (bus.i_in_last) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (bank_ready_q == 2'b00) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            fill_bank_q  <= 1'b0;
            lane_cnt_q   <= '0;
            w_len_q      <= '0;
            drop_cnt_q   <= '0;
            done_q       <= 1'b0;
            bank_ready_q <= 2'b00;
            for (int k = 0; k < W_LEN; k++) w_tab_q[k] <= '0;
            for (int b = 0; b < 2; b++) begin
                bank_cnt_q[b]  <= '0;
                bank_addr_q[b] <= '0;
                bank_ia_q[b]   <= '0;
                bank_w_q[b]    <= '0;
            end
        end else begin
            state_q      <= state_d;
            fill_bank_q  <= fill_bank_d;
            lane_cnt_q   <= lane_cnt_d;
            w_len_q      <= w_len_d;
            w_tab_q      <= w_tab_d;
            drop_cnt_q   <= drop_cnt_d;
            done_q       <= done_d;
            bank_ready_q <= bank_ready_d;
            bank_cnt_q   <= bank_cnt_d;
            bank_addr_q  <= bank_addr_d;
            bank_ia_q    <= bank_ia_d;
            bank_w_q     <= bank_w_d;
        end
    end

    assign bus.o_in_ready    = in_ready;
    assign bus.o_left_ready  = bank_ready_q[0];
    assign bus.o_left_cnt    = bank_cnt_q[0];
    assign bus.o_left_addr   = bank_ready_q[0] ? bank_addr_q[0] : '0;
    assign bus.o_left_ia     = bank_ready_q[0] ? bank_ia_q[0]   : '0;
    assign bus.o_left_w      = bank_ready_q[0] ? bank_w_q[0]    : '0;
    assign bus.o_right_ready = bank_ready_q[1];
    assign bus.o_right_cnt   = bank_cnt_q[1];
    assign bus.o_right_addr  = bank_ready_q[1] ? bank_addr_q[1] : '0;
    assign bus.o_right_ia    = bank_ready_q[1] ? bank_ia_q[1]   : '0;
    assign bus.o_right_w     = bank_ready_q[1] ? bank_w_q[1]    : '0;
    assign bus.o_drop_cnt    = drop_cnt_q;
    assign bus.o_done        = done_q;
endmodule
